// File: rtl/digit_scan_driver.sv
// Time-division scanner for a multiplexed 7-segment display.
// Lights one digit position at a time for PRESC cycles. A BLANK-cycle dark
// gap separates slots so the segment bus can settle without ghosting. Digits
// masked off in dig_mask are skipped, and the display goes dark whenever
// power is low.
module digit_scan_driver #(
  parameter int         N_DIG   = 5,
  parameter int         PRESC   = 50000,
  parameter int         BLANK   = 500,
  parameter logic [6:0] SEG_OFF = 7'h7F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic [N_DIG-1:0]   dig_mask,
  input  logic [7*N_DIG-1:0] seg_in,
  output logic [N_DIG-1:0]   dig,
  output logic [6:0]         seg,
  output logic [2:0]         scan_idx,
  output logic               frame_tick
);

  localparam int CNT_MAX    = (PRESC > BLANK) ? PRESC : BLANK;
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;
  localparam int BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;
  localparam bit NO_GAP     = (BLANK == 0);
  localparam logic [2:0] IDX_LAST = 3'(N_DIG - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_DIG-1:0]   r_dig;
  logic [6:0]         r_seg;
  logic [2:0]         r_idx;
  logic               r_tick;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [N_DIG-1:0]   w_dig_nxt;
  logic [6:0]         w_seg_nxt;
  logic [2:0]         w_idx_nxt;
  logic               w_tick_nxt;

  logic [3:0]         w_srch;
  logic               w_found;
  logic [2:0]         w_nxt;
  logic               w_blank_end;
  logic               w_show_end;
  logic               w_search;
  logic               w_enter_show;

  // First enabled position strictly above cur; if none, wrap and take the
  // lowest enabled position at or below cur. Result is {found, index}.
  function automatic logic [3:0] find_next(input logic [2:0] cur,
                                           input logic [N_DIG-1:0] mask);
    logic       found_hi;
    logic       found_lo;
    logic [2:0] hi;
    logic [2:0] lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi       = '0;
    lo       = '0;
    // Walk downward so the last hit in each half is the lowest index.
    for (int i = N_DIG - 1; i >= 0; i--) begin
      if (mask[i]) begin
        if (3'(i) > cur) begin
          found_hi = 1'b1;
          hi       = 3'(i);
        end else begin
          found_lo = 1'b1;
          lo       = 3'(i);
        end
      end
    end
    if (found_hi) return {1'b1, hi};
    return {found_lo, lo};
  endfunction

  // Active-low one-cold digit enable for position idx.
  function automatic logic [N_DIG-1:0] dig_enable(input logic [2:0] idx);
    logic [N_DIG-1:0] v;
    for (int i = 0; i < N_DIG; i++) v[i] = (3'(i) != idx);
    return v;
  endfunction

  // Segment pattern of position idx taken from the packed input bus.
  function automatic logic [6:0] seg_slice(input logic [7*N_DIG-1:0] bus,
                                           input logic [2:0] idx);
    logic [6:0] s;
    s = SEG_OFF;
    for (int i = 0; i < N_DIG; i++) begin
      if (3'(i) == idx) s = bus[7*i +: 7];
    end
    return s;
  endfunction

  assign w_srch       = find_next(r_idx, dig_mask);
  assign w_found      = w_srch[3];
  assign w_nxt        = w_srch[2:0];
  assign w_blank_end  = (r_cnt == CNT_W'(BLANK_LAST));
  assign w_show_end   = (r_cnt == CNT_W'(PRESC - 1));
  // With no gap, the next digit is chosen directly on the last SHOW cycle.
  assign w_search     = power && (((r_state == S_BLANK) && w_blank_end) ||
                                  ((r_state == S_SHOW) && w_show_end && NO_GAP));
  assign w_enter_show = w_search && w_found;

  // State register: state, slot counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dig   <= '1;
      r_seg   <= SEG_OFF;
      r_idx   <= IDX_LAST;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dig   <= w_dig_nxt;
      r_seg   <= w_seg_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Next state and slot counter; power loss always drops to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    if (!power) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
        end
        S_BLANK: begin
          if (w_blank_end) begin
            w_cnt_nxt = '0;
            if (w_found) w_state_nxt = S_SHOW;
          end
        end
        S_SHOW: begin
          if (w_show_end) begin
            w_cnt_nxt   = '0;
            w_state_nxt = w_enter_show ? S_SHOW : S_BLANK;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Next output values: dark unless a slot is starting or continuing.
  always_comb begin
    w_dig_nxt  = '1;
    w_seg_nxt  = SEG_OFF;
    w_idx_nxt  = r_idx;
    w_tick_nxt = 1'b0;
    if (power) begin
      if (r_state == S_IDLE) begin
        // Parking at the top index makes the first search land on the lowest enabled digit.
        w_idx_nxt = IDX_LAST;
      end else if (w_enter_show) begin
        w_dig_nxt  = dig_enable(w_nxt);
        w_seg_nxt  = seg_slice(seg_in, w_nxt);
        w_idx_nxt  = w_nxt;
        w_tick_nxt = (w_nxt <= r_idx);
      end else if ((r_state == S_SHOW) && !w_show_end) begin
        w_dig_nxt = dig_enable(r_idx);
        w_seg_nxt = seg_slice(seg_in, r_idx);
      end
    end
  end

  assign dig        = r_dig;
  assign seg        = r_seg;
  assign scan_idx   = r_idx;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Testbench for digit_scan_driver: one instance with a 1-cycle blanking gap
// and one with no gap, both compared every cycle against a slot-level
// behavioural model, plus directed checks on the key scan scenarios.
module tb_digit_scan_driver;

  localparam int N = 5;
  localparam int P = 4;
  localparam int OFF  = 0;
  localparam int DARK = 1;
  localparam int LIT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        power;
  logic [4:0]  mask;
  logic [34:0] seg_in;

  logic [4:0]  a_dig, b_dig;
  logic [6:0]  a_seg, b_seg;
  logic [2:0]  a_idx, b_idx;
  logic        a_tick, b_tick;

  always #5 clk = ~clk;

  digit_scan_driver #(.N_DIG(N), .PRESC(P), .BLANK(1), .SEG_OFF(7'h7F)) u_gap (
    .clk(clk), .rst(rst), .power(power), .dig_mask(mask), .seg_in(seg_in),
    .dig(a_dig), .seg(a_seg), .scan_idx(a_idx), .frame_tick(a_tick)
  );

  digit_scan_driver #(.N_DIG(N), .PRESC(P), .BLANK(0), .SEG_OFF(7'h7F)) u_nogap (
    .clk(clk), .rst(rst), .power(power), .dig_mask(mask), .seg_in(seg_in),
    .dig(b_dig), .seg(b_seg), .scan_idx(b_idx), .frame_tick(b_tick)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model: per instance, phase (off / dark / lit), cycles spent
  // in the phase, selected digit and the pattern latched for it.
  int         m_ph  [2];
  int         m_age [2];
  int         m_idx [2];
  logic [6:0] m_seg [2];
  bit         m_tick[2];

  function automatic int blank_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic logic [6:0] slice(input int i);
    return 7'(seg_in >> (7 * i));
  endfunction

  function automatic int next_on(input int cur, input logic [4:0] m);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (cur + k) % N;
      if (((m >> j) & 5'd1) != 5'd0) return j;
    end
    return -1;
  endfunction

  task automatic select_next(input int k);
    int n;
    n = next_on(m_idx[k], mask);
    if (n < 0) begin
      m_ph[k]  = DARK;
      m_age[k] = 1;
    end else begin
      m_tick[k] = (n <= m_idx[k]);
      m_idx[k]  = n;
      m_ph[k]   = LIT;
      m_age[k]  = 1;
      m_seg[k]  = slice(n);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 1'b0;
      if (rst) begin
        m_ph[k]  = OFF;
        m_idx[k] = N - 1;
      end else if (!power) begin
        m_ph[k] = OFF;
      end else begin
        case (m_ph[k])
          OFF: begin
            m_ph[k]  = DARK;
            m_age[k] = 1;
            m_idx[k] = N - 1;
          end
          DARK: begin
            if (m_age[k] >= ((blank_of(k) > 0) ? blank_of(k) : 1)) select_next(k);
            else m_age[k]++;
          end
          default: begin
            if (m_age[k] == P) begin
              if (blank_of(k) == 0) select_next(k);
              else begin
                m_ph[k]  = DARK;
                m_age[k] = 1;
              end
            end else begin
              m_age[k]++;
              m_seg[k] = slice(m_idx[k]);
            end
          end
        endcase
      end
    end
  endtask

  function automatic logic [4:0] exp_dig(input int k);
    if (m_ph[k] == LIT) return ~(5'd1 << m_idx[k]);
    return 5'h1F;
  endfunction

  function automatic logic [6:0] exp_seg(input int k);
    if (m_ph[k] == LIT) return m_seg[k];
    return 7'h7F;
  endfunction

  int cyc       = 0;
  int last_tick = -1;
  int gap_a     = 0;
  int b_dark    = 0;

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("gap.dig",  32'(a_dig),  32'(exp_dig(0)));
    chk("gap.seg",  32'(a_seg),  32'(exp_seg(0)));
    chk("gap.idx",  32'(a_idx),  32'(m_idx[0]));
    chk("gap.tick", 32'(a_tick), 32'(m_tick[0]));
    chk("nogap.dig",  32'(b_dig),  32'(exp_dig(1)));
    chk("nogap.seg",  32'(b_seg),  32'(exp_seg(1)));
    chk("nogap.idx",  32'(b_idx),  32'(m_idx[1]));
    chk("nogap.tick", 32'(b_tick), 32'(m_tick[1]));
    chk("gap.onecold",   32'($countones(~a_dig) <= 1), 32'd1);
    chk("nogap.onecold", 32'($countones(~b_dig) <= 1), 32'd1);
    if (a_tick) begin
      if (last_tick >= 0) gap_a = cyc - last_tick;
      last_tick = cyc;
    end
    if (b_dig == 5'h1F) b_dark++;
  endtask

  task automatic wait_lit(input int d, input int max_cyc, output bit ok);
    logic [4:0] target;
    target = ~(5'd1 << d);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (a_dig == target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [34:0] count_pattern();
    logic [34:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[7*i +: 7] = 7'(i + 1);
    return v;
  endfunction

  initial begin
    bit ok;
    rst    = 1'b1;
    power  = 1'b0;
    mask   = 5'b11111;
    seg_in = count_pattern();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = OFF; m_age[k] = 0; m_idx[k] = N - 1; m_seg[k] = 7'h7F; m_tick[k] = 1'b0;
    end
    cycle();
    cycle();
    chk("rst.dig",  32'(a_dig),  32'h1F);
    chk("rst.seg",  32'(a_seg),  32'h7F);
    chk("rst.idx",  32'(a_idx),  32'd4);
    chk("rst.tick", 32'(a_tick), 32'd0);

    // Full mask scan from reset.
    rst   = 1'b0;
    power = 1'b1;
    cycle();
    chk("t1.blank", 32'(a_dig), 32'h1F);
    cycle();
    chk("t1.first_dig",  32'(a_dig),  32'b11110);
    chk("t1.first_seg",  32'(a_seg),  32'd1);
    chk("t1.first_tick", 32'(a_tick), 32'd1);
    repeat (4) cycle();
    chk("t1.gap_dark", 32'(a_dig), 32'h1F);
    cycle();
    chk("t1.second_dig", 32'(a_dig), 32'b11101);
    chk("t1.second_seg", 32'(a_seg), 32'd2);
    repeat (60) cycle();
    chk("t1.frame_period", 32'(gap_a), 32'd25);

    // Sparse mask: digits 0 and 3 only.
    mask = 5'b01001;
    repeat (60) cycle();
    chk("t2.frame_period", 32'(gap_a), 32'd10);

    // Mask cleared during a digit-2 slot, then digit 2 re-enabled.
    mask = 5'b11111;
    wait_lit(2, 100, ok);
    chk("t3.reach_d2", 32'(ok), 32'd1);
    mask = 5'b00000;
    repeat (30) cycle();
    chk("t3.dark", 32'(a_dig), 32'h1F);
    mask = 5'b00100;
    wait_lit(2, 20, ok);
    chk("t3.resume", 32'(ok), 32'd1);
    chk("t3.resume_tick", 32'(a_tick), 32'd1);

    // Power loss on the second cycle of a slot, then restore.
    mask = 5'b01010;
    wait_lit(3, 100, ok);
    chk("t4.reach_d3", 32'(ok), 32'd1);
    cycle();
    power = 1'b0;
    cycle();
    chk("t4.off_dig", 32'(a_dig), 32'h1F);
    chk("t4.off_seg", 32'(a_seg), 32'h7F);
    repeat (3) cycle();
    power = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (a_dig != 5'h1F) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4.restart", 32'(ok), 32'd1);
    chk("t4.restart_idx", 32'(a_idx), 32'd1);
    chk("t4.restart_tick", 32'(a_tick), 32'd1);

    // Reset mid-slot wins over power.
    wait_lit(3, 100, ok);
    chk("t5.reach_d3", 32'(ok), 32'd1);
    cycle();
    rst = 1'b1;
    cycle();
    chk("t5.dig",  32'(a_dig),  32'h1F);
    chk("t5.seg",  32'(a_seg),  32'h7F);
    chk("t5.idx",  32'(a_idx),  32'd4);
    chk("t5.tick", 32'(a_tick), 32'd0);
    rst = 1'b0;

    // No-gap instance: digits 0 and 1 alternate with no dark cycle.
    mask = 5'b00011;
    repeat (10) cycle();
    b_dark = 0;
    repeat (40) cycle();
    chk("t6.no_dark", 32'(b_dark), 32'd0);

    // Randomized traffic: patterns, masks, power drops and resets.
    for (int i = 0; i < 800; i++) begin
      seg_in = 35'({$urandom(), $urandom()});
      if ($urandom_range(0, 39) == 0) mask = 5'($urandom());
      if (power) begin
        if ($urandom_range(0, 79) == 0) power = 1'b0;
      end else if ($urandom_range(0, 5) == 0) power = 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
